reg_pipe: RTL



---
 rtl/reg_pipe.sv | 87 ++++++++
 1 files changed

// File: rtl/reg_pipe.sv
// rtl/reg_pipe.sv - elastic val/rdy pipeline register, DEPTH stages of WIDTH bits with bubble collapsing
// Optional occupancy output `count` is enabled by defining REG_PIPE_COUNT_EN.
module reg_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_msg
`ifdef REG_PIPE_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [DEPTH-1:0] w_adv;
    logic             w_in_xfer;

    // A stage may advance if the output drains or any stage ahead of it is a bubble.
    // Written as a flat OR over downstream stages so the ready chain has no self-feedback.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_adv[i] = out_rdy;
            for (int j = i + 1; j < DEPTH; j++) begin
                if (!r_v[j]) begin
                    w_adv[i] = 1'b1;
                end
            end
        end
    end

    assign in_rdy    = !r_v[0] || w_adv[0];
    assign w_in_xfer = in_val && in_rdy;
    assign out_val   = r_v[DEPTH-1];
    assign out_msg   = r_d[DEPTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else begin
            if (w_in_xfer) begin
                r_v[0] <= 1'b1;
                r_d[0] <= in_msg;
            end else if (w_adv[0]) begin
                r_v[0] <= 1'b0;
            end
            // Data registers only load when a valid message moves in, otherwise they hold.
            for (int i = 1; i < DEPTH; i++) begin
                if (w_adv[i-1]) begin
                    r_v[i] <= r_v[i-1];
                    if (r_v[i-1]) begin
                        r_d[i] <= r_d[i-1];
                    end
                end
            end
        end
    end

`ifdef REG_PIPE_COUNT_EN
    localparam int CW = $clog2(DEPTH + 1);

    logic          w_out_xfer;
    logic [CW-1:0] r_count;

    assign w_out_xfer = r_v[DEPTH-1] && out_rdy;
    assign count      = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
        end
    end
`endif

endmodule
